// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Load/store responder with programmable wait, byte/half/word lane
//            access on an internal word array, and valid/ready handshakes.
//            Optional error detection is enabled by defining DMEM_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_CW    = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [c_CW-1:0] c_LAT = c_CW'(LATENCY);
    localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic            r_we, r_uns;
    logic [31:0]     r_addr, r_wdata;
    logic [1:0]      r_size;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [0:c_DEPTH-1];

    logic            w_req_hs, w_access;
    logic            w_we, w_uns, w_err;
    logic [31:0]     w_addr, w_wdata;
    logic [1:0]      w_size;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [3:0]      w_be;
    logic [31:0]     w_old, w_wword, w_new, w_load, w_rdata_nxt;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    // With zero latency the access happens on the accept edge, so the live
    // request fields are used while idle; otherwise the captured copy.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_we = req_we; w_addr = req_addr; w_wdata = req_wdata;
            w_size = req_size; w_uns = req_unsigned;
        end else begin
            w_we = r_we; w_addr = r_addr; w_wdata = r_wdata;
            w_size = r_size; w_uns = r_uns;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        w_req_hs    = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = rst;
                w_req_hs  = req_valid & rst;
                if (w_req_hs) begin
                    if (LATENCY == 0) begin
                        w_access    = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_cnt_nxt   = c_LAT;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_idx = w_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_ERR_EN
    assign w_err = (w_size == 2'b01 && w_addr[0])
                 | (w_size == 2'b10 && w_addr[1:0] != 2'b00)
                 | (w_size == 2'b11)
                 | ((w_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
`else
    // Without error detection the upper address bits simply wrap.
    logic w_unused_addr;
    assign w_unused_addr = |(w_addr >> (DEPTH_LOG2 + 2));
    assign w_err = 1'b0;
`endif

    // Lane enables ignore the low address bits a larger size cannot use,
    // which realigns misaligned accesses when errors are not reported.
    always_comb begin
        w_old = r_mem[w_idx];
        if (w_size == 2'b00) begin
            w_be    = 4'b0001 << w_addr[1:0];
            w_wword = {4{w_wdata[7:0]}};
        end else if (w_size == 2'b01) begin
            w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wword = {2{w_wdata[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wword = w_wdata;
        end
        for (int i = 0; i < 4; i++) begin
            w_new[8*i +: 8] = w_be[i] ? w_wword[8*i +: 8] : w_old[8*i +: 8];
        end
        w_byte = w_old[{w_addr[1:0], 3'b000} +: 8];
        w_half = w_addr[1] ? w_old[31:16] : w_old[15:0];
        if (w_size == 2'b00)
            w_load = {{24{~w_uns & w_byte[7]}}, w_byte};
        else if (w_size == 2'b01)
            w_load = {{16{~w_uns & w_half[15]}}, w_half};
        else
            w_load = w_old;
        w_rdata_nxt = (w_we | w_err) ? 32'd0 : w_load;
    end

    always_ff @(posedge clk) begin
        if (w_access && w_we && !w_err) r_mem[w_idx] <= w_new;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_req_hs) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_size  <= req_size;
            end
            if (w_access) begin
                r_rdata <= w_rdata_nxt;
                r_err   <= w_err;
            end else if (r_state == S_RESP && resp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Self-checking bench for data_mem_responder against a byte-array
//            reference model; follows DMEM_ERR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DL2 = 8;
    localparam int LAT = 2;
    localparam int NB  = 4 << DL2;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem_b [0:NB-1];

    data_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed little-endian reference of the access rules.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic uns,
                                  output logic [31:0] rd, output logic err);
        int nb, base;
        logic [31:0] a;
        logic [1:0] sz;
        rd = 32'd0; err = 1'b0; sz = size; a = addr;
`ifdef DMEM_ERR_EN
        if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || sz == 2'd3 || a >= 32'(NB)) begin
            err = 1'b1;
            return;
        end
`else
        if (sz == 2'd3) sz = 2'd2;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'd0;
`endif
        nb   = 1 << sz;
        base = int'(a % 32'(NB));
        if (we) begin
            for (int i = 0; i < nb; i++) mem_b[base+i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) rd = rd | (32'(mem_b[base+i]) << (8*i));
            if (nb < 4 && !uns && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
        end
    endfunction

    // Drives one transaction; ok drops on timeout, response instability,
    // a non-idle responder at the start, or a response that does not retire.
    task automatic bus_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, input int hold,
                           output logic [31:0] rd, output logic er, output int lat, output logic ok);
        ok = 1'b1; lat = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        resp_ready = (hold == 0);
        if (req_ready !== 1'b1) ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        while (resp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (resp_valid !== 1'b1) begin
            ok = 1'b0; rd = 'x; er = 1'bx;
            return;
        end
        rd = resp_rdata; er = resp_err;
        for (int c = 0; c < hold; c++) begin
            req_valid = c[0]; req_we = 1'b1; req_addr = addr & 32'hFFFF_FFFC;
            req_size = 2'd2; req_wdata = $urandom;
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0) ok = 1'b0;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
    endtask

    task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input int hold,
                       output logic [31:0] rd, output logic er,
                       output logic [31:0] erd, output logic eer, output int lat, output logic ok);
        model(we, addr, wdata, size, uns, erd, eer);
        bus_txn(we, addr, wdata, size, uns, hold, rd, er, lat, ok);
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h err=%b, want 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        rst = 1'b1; #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_init();
        logic [31:0] rd, erd; logic er, eer, ok; int lat; int bad;
        bad = 0;
        for (int w = 0; w < (1 << DL2); w++) begin
            run(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
            if (!ok || er !== 1'b0 || rd !== 32'd0 || lat != LAT) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init_fill: got %0d bad stores, want 0", bad);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, erd; logic er, eer, ok; int lat;
        run(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || lat != LAT || er !== 1'b0) begin
            errors++;
            $display("FAIL word_store: got ok=%b lat=%0d err=%b want 1 %0d 0", ok, lat, er, LAT);
        end
        run(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || lat != LAT || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL word_load: got ok=%b lat=%0d rdata=%h err=%b want 1 %0d deadbeef 0", ok, lat, rd, er, LAT);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, erd; logic er, eer, ok; int lat;
        run(1'b1, 32'h10, 32'h1122_3344, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        run(1'b1, 32'h13, 32'h0000_0080, 2'd0, 1'b0, 0, rd, er, erd, eer, lat, ok);
        run(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || rd !== 32'hFFFF_FF80 || rd !== erd) begin
            errors++;
            $display("FAIL byte_signed: got %h want ffffff80", rd);
        end
        run(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || rd !== 32'h0000_0080) begin
            errors++;
            $display("FAIL byte_unsigned: got %h want 00000080", rd);
        end
        run(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || rd !== 32'h8022_3344) begin
            errors++;
            $display("FAIL byte_merge_word: got %h want 80223344", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd, erd; logic er, eer, ok; int lat;
        run(1'b1, 32'h10, 32'h8001_7FFF, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        run(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || rd !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL half_upper_signed: got %h want ffff8001", rd);
        end
        run(1'b0, 32'h10, 32'h0, 2'd1, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || rd !== 32'h0000_7FFF) begin
            errors++;
            $display("FAIL half_lower_signed: got %h want 00007fff", rd);
        end
    endtask

`ifdef DMEM_ERR_EN
    task automatic test_errors();
        logic [31:0] rd, erd; logic er, eer, ok; int lat;
        run(1'b1, 32'h21, 32'h1234_5678, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL err_misaligned_store: got err=%b rdata=%h want 1 0", er, rd);
        end
        run(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== erd) begin
            errors++;
            $display("FAIL err_no_write: got %h err=%b want %h 0", rd, er, erd);
        end
        run(1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL err_out_of_range: got err=%b rdata=%h want 1 0", er, rd);
        end
        run(1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || er !== 1'b1) begin
            errors++;
            $display("FAIL err_half_misaligned: got err=%b want 1", er);
        end
        run(1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || er !== 1'b1) begin
            errors++;
            $display("FAIL err_reserved_size: got err=%b want 1", er);
        end
    endtask
`else
    task automatic test_errors();
        logic [31:0] rd, erd; logic er, eer, ok; int lat;
        run(1'b1, 32'h10, 32'h8001_7FFF, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        run(1'b0, 32'h13, 32'h0, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== 32'h8001_7FFF) begin
            errors++;
            $display("FAIL align_word: got %h err=%b want 80017fff 0", rd, er);
        end
        run(1'b0, 32'h13, 32'h0, 2'd1, 1'b1, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || rd !== 32'h0000_8001) begin
            errors++;
            $display("FAIL align_half: got %h want 00008001", rd);
        end
        run(1'b0, 32'h410, 32'h0, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== 32'h8001_7FFF) begin
            errors++;
            $display("FAIL wrap_index: got %h err=%b want 80017fff 0", rd, er);
        end
        run(1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || rd !== 32'h8001_7FFF) begin
            errors++;
            $display("FAIL reserved_as_word: got %h want 80017fff", rd);
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [31:0] rd, erd; logic er, eer, ok; int lat;
        run(1'b1, 32'h30, 32'hA5A5_5A5A, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        run(1'b0, 32'h30, 32'h0, 2'd2, 1'b0, 5, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || rd !== 32'hA5A5_5A5A || er !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold: got ok=%b rdata=%h err=%b want 1 a5a55a5a 0", ok, rd, er);
        end
        run(1'b0, 32'h30, 32'h0, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || rd !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL backpressure_ignored_req: got %h want a5a55a5a", rd);
        end
    endtask

    task automatic test_reset_midwait();
        logic [31:0] rd, erd; logic er, eer, ok; int lat; int n;
        run(1'b1, 32'h8, 32'h0, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hCAFE_F00D;
        req_size = 2'd2; req_unsigned = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait: got vld=%b rdata=%h err=%b rdy=%b want 0 0 0 0",
                     resp_valid, resp_rdata, resp_err, req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1; #1;
        run(1'b0, 32'h8, 32'h0, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
        checks++;
        if (!ok || rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort_no_write: got %h want 00000000", rd);
        end
        // Pending response is dropped by reset.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b0; #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || n != LAT) begin
            errors++;
            $display("FAIL reset_in_resp: got vld=%b rdata=%h lat=%0d want 0 0 %0d", resp_valid, resp_rdata, n, LAT);
        end
        @(posedge clk); #1;
        rst = 1'b1; #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd, a, d; logic er, eer, ok; int lat;
        for (int i = 0; i < 20; i++) begin
            a = 32'($urandom_range(0, (1 << DL2) - 1)) << 2;
            d = $urandom;
            run(1'b1, a, d, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
            run(1'b0, a, 32'h0, 2'd2, 1'b0, 0, rd, er, erd, eer, lat, ok);
            checks++;
            if (!ok || rd !== d) begin
                errors++;
                $display("FAIL store_then_load @%h: got %h want %h", a, rd, d);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a; logic er, eer, ok, we, uns; logic [1:0] sz; int lat, hold;
        for (int i = 0; i < 300; i++) begin
`ifdef DMEM_ERR_EN
            a = 32'($urandom_range(0, NB - 1));
            if ($urandom_range(0, 7) == 0) a = $urandom;
`else
            a = $urandom;
`endif
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            hold = $urandom_range(0, 2);
            run(we, a, $urandom, sz, uns, hold, rd, er, erd, eer, lat, ok);
            checks++;
            if (!ok || lat != LAT) begin
                errors++;
                $display("FAIL rand_handshake #%0d: got ok=%b lat=%0d want 1 %0d", i, ok, lat, LAT);
            end
            checks++;
            if (rd !== erd || er !== eer) begin
                errors++;
                $display("FAIL rand_data #%0d we=%b a=%h sz=%0d u=%b: got %h/%b want %h/%b",
                         i, we, a, sz, uns, rd, er, erd, eer);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word();
        test_byte_lanes();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_midwait();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
